// File: rtl/trace_replay_driver.sv
// trace_replay_driver
// Holds a preloaded memory-op trace and replays it as dcache requests across
// NUM_PORTS channels. Each entry can wait a number of idle cycles before it
// issues, and each channel can stall its own request. Replay runs once or loops.
// All request outputs come from registers, so stall never reaches req_* through
// combinational logic.
module trace_replay_driver #(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int PC_W      = 32,
    parameter int GAP_W     = 4,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_port,
    input  logic                 wr_mem_op,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [1:0]           wr_size,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [PC_W-1:0]      wr_pc,
    input  logic [GAP_W-1:0]     wr_gap,
    output logic                 wr_full,
    input  logic                 start,
    input  logic                 loop_mode,
    input  logic                 abort,
    input  logic [NUM_PORTS-1:0] stall,
    output logic [NUM_PORTS-1:0] req_valid,
    output logic                 req_mem_op,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [1:0]           req_size,
    output logic [DATA_W-1:0]    req_data,
    output logic [PC_W-1:0]      req_pc,
    output logic [IW-1:0]        req_index,
    output logic                 busy,
    output logic                 finish,
    output logic [15:0]          loop_count
);

    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // Trace table storage (contents are don't-care after reset)
    logic [PW-1:0]     portMem [DEPTH];
    logic              opMem   [DEPTH];
    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [1:0]        sizeMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PC_W-1:0]   pcMem   [DEPTH];
    logic [GAP_W-1:0]  gapMem  [DEPTH];

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     rdPtr_q, rdPtr_d;
    logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
    logic              loopMode_q, loopMode_d;
    logic [15:0]       loopCount_q, loopCount_d;

    logic [NUM_PORTS-1:0] reqValid_q, reqValid_d;
    logic                 reqOp_q, reqOp_d;
    logic [ADDR_W-1:0]    reqAddr_q, reqAddr_d;
    logic [1:0]           reqSize_q, reqSize_d;
    logic [DATA_W-1:0]    reqData_q, reqData_d;
    logic [PC_W-1:0]      reqPc_q, reqPc_d;
    logic [IW-1:0]        reqIndex_q, reqIndex_d;
    logic                 busy_q, finish_q, wrFull_q;

    logic          full;
    logic          tableWe;
    logic          accepted;
    logic          lastEntry;
    logic          beginReplay;
    logic          doEnter;
    logic [IW-1:0] enterIdx;

    assign full      = (count_q == CW'(DEPTH));
    assign tableWe   = (state_q == ST_IDLE) && wr_en && !abort && !full;
    assign accepted  = (state_q == ST_ISSUE) && ((reqValid_q & ~stall) != '0);
    assign lastEntry = ({1'b0, rdPtr_q} == (count_q - CW'(1)));

    // Append an entry at the current fill level; out-of-range channels fall back to channel 0
    always_ff @(posedge clock) begin
        if (tableWe) begin
            portMem[count_q[IW-1:0]] <= (32'(wr_port) < NUM_PORTS) ? wr_port : '0;
            opMem[count_q[IW-1:0]]   <= wr_mem_op;
            addrMem[count_q[IW-1:0]] <= wr_addr;
            sizeMem[count_q[IW-1:0]] <= wr_size;
            dataMem[count_q[IW-1:0]] <= wr_data;
            pcMem[count_q[IW-1:0]]   <= wr_pc;
            gapMem[count_q[IW-1:0]]  <= wr_gap;
        end
    end

    // Replay sequencing: abort first, then per-state progress; entering an entry picks GAP or ISSUE from its gap
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rdPtr_d     = rdPtr_q;
        gapCnt_d    = gapCnt_q;
        loopMode_d  = loopMode_q;
        loopCount_d = loopCount_q;
        beginReplay = 1'b0;
        doEnter     = 1'b0;
        enterIdx    = '0;

        if (abort) begin
            if (state_q == ST_IDLE) begin
                count_d = '0;
            end else begin
                state_d = ST_IDLE;
                rdPtr_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tableWe) begin
                        count_d = count_q + CW'(1);
                    end
                    beginReplay = start;
                end
                ST_GAP: begin
                    if (gapCnt_q <= GAP_W'(1)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        gapCnt_d = gapCnt_q - GAP_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (accepted) begin
                        if (lastEntry) begin
                            if (loopMode_q) begin
                                rdPtr_d = '0;
                                if (loopCount_q != 16'hFFFF) begin
                                    loopCount_d = loopCount_q + 16'd1;
                                end
                                doEnter  = 1'b1;
                                enterIdx = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            rdPtr_d  = rdPtr_q + IW'(1);
                            doEnter  = 1'b1;
                            enterIdx = rdPtr_q + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    beginReplay = start;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (beginReplay) begin
            if (count_q == '0) begin
                state_d = ST_DONE;
            end else begin
                loopMode_d  = loop_mode;
                rdPtr_d     = '0;
                loopCount_d = '0;
                doEnter     = 1'b1;
                enterIdx    = '0;
            end
        end

        if (doEnter) begin
            if (gapMem[enterIdx] == '0) begin
                state_d = ST_ISSUE;
            end else begin
                state_d  = ST_GAP;
                gapCnt_d = gapMem[enterIdx];
            end
        end
    end

    // Request fields for the next cycle: present entry rdPtr_d while issuing, otherwise drop valid and hold fields
    always_comb begin
        reqValid_d = '0;
        reqOp_d    = reqOp_q;
        reqAddr_d  = reqAddr_q;
        reqSize_d  = reqSize_q;
        reqData_d  = reqData_q;
        reqPc_d    = reqPc_q;
        reqIndex_d = reqIndex_q;
        if (state_d == ST_ISSUE) begin
            reqValid_d = NUM_PORTS'(1) << portMem[rdPtr_d];
            reqOp_d    = opMem[rdPtr_d];
            reqAddr_d  = addrMem[rdPtr_d];
            reqSize_d  = sizeMem[rdPtr_d];
            reqData_d  = dataMem[rdPtr_d];
            reqPc_d    = pcMem[rdPtr_d];
            reqIndex_d = rdPtr_d;
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rdPtr_q     <= '0;
            gapCnt_q    <= '0;
            loopMode_q  <= 1'b0;
            loopCount_q <= '0;
            reqValid_q  <= '0;
            reqOp_q     <= 1'b0;
            reqAddr_q   <= '0;
            reqSize_q   <= '0;
            reqData_q   <= '0;
            reqPc_q     <= '0;
            reqIndex_q  <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            wrFull_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rdPtr_q     <= rdPtr_d;
            gapCnt_q    <= gapCnt_d;
            loopMode_q  <= loopMode_d;
            loopCount_q <= loopCount_d;
            reqValid_q  <= reqValid_d;
            reqOp_q     <= reqOp_d;
            reqAddr_q   <= reqAddr_d;
            reqSize_q   <= reqSize_d;
            reqData_q   <= reqData_d;
            reqPc_q     <= reqPc_d;
            reqIndex_q  <= reqIndex_d;
            busy_q      <= (state_d == ST_GAP) || (state_d == ST_ISSUE);
            finish_q    <= (state_d == ST_DONE);
            wrFull_q    <= (count_d == CW'(DEPTH));
        end
    end

    assign req_valid  = reqValid_q;
    assign req_mem_op = reqOp_q;
    assign req_addr   = reqAddr_q;
    assign req_size   = reqSize_q;
    assign req_data   = reqData_q;
    assign req_pc     = reqPc_q;
    assign req_index  = reqIndex_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign wr_full    = wrFull_q;
    assign loop_count = loopCount_q;

endmodule

// File: tb/tb_trace_replay_driver.sv
// Testbench for trace_replay_driver: loads traces from vector tables, replays
// them, and matches every accepted request against a scoreboard queue.
module tb_trace_replay_driver;

    localparam int NP    = 2;
    localparam int DEPTH = 64;

    typedef struct {
        logic [0:0]  port;
        logic        op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        logic [31:0] pc;
        logic [3:0]  gap;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [1:0]  valid;
        logic        op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        logic [31:0] pc;
        logic [5:0]  index;
        int          cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [0:0]    wr_port = '0;
    logic          wr_mem_op = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [1:0]    wr_size = '0;
    logic [63:0]   wr_data = '0;
    logic [31:0]   wr_pc = '0;
    logic [3:0]    wr_gap = '0;
    logic          wr_full;
    logic          start = 1'b0;
    logic          loop_mode = 1'b0;
    logic          abort = 1'b0;
    logic [NP-1:0] stall = '0;
    logic [NP-1:0] req_valid;
    logic          req_mem_op;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [63:0]   req_data;
    logic [31:0]   req_pc;
    logic [5:0]    req_index;
    logic          busy;
    logic          finish;
    logic [15:0]   loop_count;

    trace_replay_driver #(
        .NUM_PORTS(NP), .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(64), .PC_W(32), .GAP_W(4)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_port(wr_port), .wr_mem_op(wr_mem_op), .wr_addr(wr_addr),
        .wr_size(wr_size), .wr_data(wr_data), .wr_pc(wr_pc), .wr_gap(wr_gap),
        .wr_full(wr_full), .start(start), .loop_mode(loop_mode), .abort(abort),
        .stall(stall), .req_valid(req_valid), .req_mem_op(req_mem_op),
        .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
        .req_pc(req_pc), .req_index(req_index), .busy(busy), .finish(finish),
        .loop_count(loop_count)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    exp_t        sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycNum = 0;
    int          startEdge = 0;
    logic [1:0]  snapValid;
    logic [31:0] snapAddr;
    logic [5:0]  snapIndex;
    logic        snapBusy, snapFinish, snapFull;
    logic [15:0] snapLoop;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock: sample at negedge, score any request accepted at the coming edge, then advance
    task automatic stepCycle();
        exp_t e;
        @(negedge clock);
        snapValid  = req_valid;
        snapAddr   = req_addr;
        snapIndex  = req_index;
        snapBusy   = busy;
        snapFinish = finish;
        snapFull   = wr_full;
        snapLoop   = loop_count;
        if (!abort && ((req_valid & ~stall) != '0)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedReq: got index %0d addr 0x%0h valid %b, required no request",
                         req_index, req_addr, req_valid);
            end else begin
                e = sbQ.pop_front();
                checkOutput("reqValid", 64'(req_valid), 64'(e.valid));
                checkOutput("reqAddr", 64'(req_addr), 64'(e.addr));
                checkOutput("reqMemOp", 64'(req_mem_op), 64'(e.op));
                checkOutput("reqSize", 64'(req_size), 64'(e.size));
                checkOutput("reqData", req_data, e.data);
                checkOutput("reqPc", 64'(req_pc), 64'(e.pc));
                checkOutput("reqIndex", 64'(req_index), 64'(e.index));
                if (e.cyc >= 0) checkOutput("issueCycle", 64'(cycNum + 1 - startEdge), 64'(e.cyc));
            end
        end
        @(posedge clock);
        #1;
        cycNum++;
    endtask

    // Write one trace entry
    task automatic applyStimulus(input vec_t v);
        wr_en     = 1'b1;
        wr_port   = v.port;
        wr_mem_op = v.op;
        wr_addr   = v.addr;
        wr_size   = v.size;
        wr_data   = v.data;
        wr_pc     = v.pc;
        wr_gap    = v.gap;
        stepCycle();
        wr_en     = 1'b0;
    endtask

    task automatic pushExpected(input vec_t v, input int idx, input int cyc);
        exp_t e;
        e.valid = 2'(1) << v.port;
        e.op    = v.op;
        e.addr  = v.addr;
        e.size  = v.size;
        e.data  = v.data;
        e.pc    = v.pc;
        e.index = 6'(idx);
        e.cyc   = cyc;
        sbQ.push_back(e);
    endtask

    task automatic doStart(input logic loopM);
        loop_mode = loopM;
        start     = 1'b1;
        startEdge = cycNum + 1;
        stepCycle();
        start     = 1'b0;
    endtask

    task automatic runUntilFinish(input int budget, input int expOff, input string name);
        int n = 0;
        int off;
        snapFinish = 1'b0;
        while (n < budget && !snapFinish) begin
            stepCycle();
            n++;
        end
        off = snapFinish ? (cycNum - startEdge) : -1;
        checkOutput(name, 64'(off), 64'(expOff));
    endtask

    task automatic doReset();
        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        sbQ.delete();
        stall = '0; abort = 1'b0; start = 1'b0; wr_en = 1'b0; loop_mode = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycNum++;
        reset = 1'b0;
    endtask

    vec_t trace3 [3];
    vec_t v;
    int   n;

    initial begin
        trace3[0] = '{1'b0, 1'b0, 32'h100, 2'd2, 64'h0,    32'h400, 4'd0, 1};
        trace3[1] = '{1'b1, 1'b1, 32'h200, 2'd3, 64'hDEAD, 32'h404, 4'd2, 4};
        trace3[2] = '{1'b0, 1'b0, 32'h108, 2'd2, 64'h0,    32'h408, 4'd0, 5};

        // Reset values
        #1 reset = 1'b1;
        #2;
        checkOutput("rstReqValid", 64'(req_valid), 64'd0);
        checkOutput("rstReqAddr", 64'(req_addr), 64'd0);
        checkOutput("rstReqIndex", 64'(req_index), 64'd0);
        checkOutput("rstFinish", 64'(finish), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstLoopCount", 64'(loop_count), 64'd0);
        checkOutput("rstWrFull", 64'(wr_full), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic three-entry replay, no stall
        for (int i = 0; i < 3; i++) begin
            applyStimulus(trace3[i]);
            pushExpected(trace3[i], i, trace3[i].cyc);
        end
        doStart(1'b0);
        runUntilFinish(20, 6, "basicFinishCycle");
        checkOutput("basicLoopCount", 64'(snapLoop), 64'd0);
        checkOutput("basicBusy", 64'(snapBusy), 64'd0);

        // Stall channel 1 for five presented cycles; stall[0] pulses and wr_en are ignored
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(trace3[i]);
        pushExpected(trace3[0], 0, 1);
        pushExpected(trace3[1], 1, 9);
        pushExpected(trace3[2], 2, 10);
        stall = 2'b10;
        doStart(1'b0);
        n = 0;
        snapValid = '0;
        while (n < 20 && snapValid != 2'b10) begin
            stepCycle();
            n++;
        end
        checkOutput("stallFirstPresent", 64'(cycNum - startEdge), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            stall   = (k % 2 == 1) ? 2'b11 : 2'b10;
            wr_en   = 1'b1;
            wr_port = 1'b0;
            wr_addr = 32'hBAD;
            wr_gap  = 4'd0;
            stepCycle();
            checkOutput("stallHoldValid", 64'(snapValid), 64'd2);
            checkOutput("stallHoldAddr", 64'(snapAddr), 64'h200);
            checkOutput("stallHoldIndex", 64'(snapIndex), 64'd1);
        end
        wr_en = 1'b0;
        stall = 2'b00;
        runUntilFinish(20, 11, "stallFinishCycle");

        // Looping replay, then abort, then one-shot replays from IDLE and from DONE
        doReset();
        v = '{1'b0, 1'b0, 32'h300, 2'd3, 64'h11, 32'h500, 4'd0, 0};
        applyStimulus(v);
        for (int k = 0; k < 6; k += 2) pushExpected(v, 0, k + 1);
        v = '{1'b1, 1'b1, 32'h340, 2'd1, 64'h22, 32'h504, 4'd0, 0};
        applyStimulus(v);
        for (int k = 1; k < 6; k += 2) sbQ.insert(k, '{2'b10, 1'b1, 32'h340, 2'd1, 64'h22, 32'h504, 6'd1, k + 1});
        doStart(1'b1);
        for (int k = 1; k <= 6; k++) begin
            stepCycle();
            checkOutput("loopCount", 64'(snapLoop), 64'((k - 1) / 2));
        end
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        stepCycle();
        checkOutput("abortValid", 64'(snapValid), 64'd0);
        checkOutput("abortBusy", 64'(snapBusy), 64'd0);
        checkOutput("abortFinish", 64'(snapFinish), 64'd0);
        pushExpected('{1'b0, 1'b0, 32'h300, 2'd3, 64'h11, 32'h500, 4'd0, 0}, 0, 1);
        pushExpected('{1'b1, 1'b1, 32'h340, 2'd1, 64'h22, 32'h504, 4'd0, 0}, 1, 2);
        doStart(1'b0);
        runUntilFinish(10, 3, "afterAbortFinish");
        checkOutput("afterAbortLoopCount", 64'(snapLoop), 64'd0);
        pushExpected('{1'b0, 1'b0, 32'h300, 2'd3, 64'h11, 32'h500, 4'd0, 0}, 0, 1);
        pushExpected('{1'b1, 1'b1, 32'h340, 2'd1, 64'h22, 32'h504, 4'd0, 0}, 1, 2);
        doStart(1'b0);
        runUntilFinish(10, 3, "doneRestartFinish");

        // Fill beyond DEPTH; replay must issue exactly DEPTH requests
        doReset();
        for (int i = 0; i <= DEPTH; i++) begin
            v = '{1'(i), 1'(i), 32'h1000 + 32'(i * 8), 2'd3, {32'hCAFE, 32'(i)}, 32'h8000 + 32'(i * 4), 4'd0, 0};
            applyStimulus(v);
            if (i < DEPTH) pushExpected(v, i, i + 1);
            if (i == DEPTH - 1) checkOutput("notFullBeforeLast", 64'(snapFull), 64'd0);
            if (i == DEPTH) checkOutput("fullAtDepth", 64'(snapFull), 64'd1);
        end
        stepCycle();
        checkOutput("fullHeld", 64'(snapFull), 64'd1);
        doStart(1'b0);
        wr_en = 1'b1;
        wr_addr = 32'hBAD;
        stepCycle();
        stepCycle();
        wr_en = 1'b0;
        runUntilFinish(100, DEPTH + 1, "fullFinishCycle");

        // Empty start, abort from DONE, abort clearing the table in IDLE
        doReset();
        doStart(1'b0);
        runUntilFinish(5, 1, "emptyFinishCycle");
        checkOutput("emptyNoValid", 64'(snapValid), 64'd0);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        stepCycle();
        checkOutput("abortDoneFinish", 64'(snapFinish), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus('{1'b0, 1'b0, 32'h600 + 32'(i), 2'd0, 64'h0, 32'h0, 4'd0, 0});
        abort = 1'b1;
        wr_en = 1'b1;
        stepCycle();
        abort = 1'b0;
        wr_en = 1'b0;
        doStart(1'b0);
        runUntilFinish(5, 1, "clearedFinishCycle");

        // Asynchronous reset while a stalled request is presented
        doReset();
        applyStimulus('{1'b0, 1'b0, 32'h500, 2'd2, 64'h5, 32'h0, 4'd0, 0});
        stall = 2'b01;
        doStart(1'b0);
        stepCycle();
        checkOutput("preResetValid", 64'(snapValid), 64'd1);
        checkOutput("preResetBusy", 64'(snapBusy), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRstValid", 64'(req_valid), 64'd0);
        checkOutput("asyncRstFinish", 64'(finish), 64'd0);
        checkOutput("asyncRstBusy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        cycNum++;
        reset = 1'b0;
        stall = 2'b00;
        doStart(1'b0);
        runUntilFinish(5, 1, "postResetFinish");
        checkOutput("finalQueueEmpty", 64'(sbQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
